// File: rtl/baud_share_arbiter.sv
// rtl/baud_share_arbiter.sv - round-robin sharing of one baud rate generator between TX and RX
module baud_share_arbiter #(
    parameter int SETUP_CYC = 2,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [1:0]       sel0,
    input  logic [1:0]       sel1,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic             brg_clk_in,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic [1:0]       brg_sel,
    output logic             brg_rst,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]     SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [CNT_W:0] CNT_ONE    = (CNT_W+1)'(1);
    localparam logic [CNT_W:0] LEN_MAX    = {1'b1, {CNT_W{1'b0}}};

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic             prev_q, prev_d;
    logic [CNT_W:0]   cnt_q, cnt_d;
    logic [CNT_W:0]   len_q, len_d;
    logic [3:0]       tmr_q, tmr_d;

    logic             tick;
    logic             pick;
    logic [CNT_W-1:0] len_pick;

    assign tick     = brg_clk_in & ~prev_q;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick     = (req == 2'b10) | ((req == 2'b11) & ~last_q);
    assign len_pick = pick ? len1 : len0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        win_d   = win_q;
        last_d  = last_q;
        prev_d  = brg_clk_in;
        cnt_d   = cnt_q;
        len_d   = len_q;
        tmr_d   = tmr_q;
        case (state_q)
            S_IDLE: begin
                gnt_d = 2'b00;
                if (req != 2'b00) begin
                    state_d = S_SETUP;
                    win_d   = pick;
                    gnt_d   = pick ? 2'b10 : 2'b01;
                    sel_d   = pick ? sel1 : sel0;
                    len_d   = (len_pick == '0) ? LEN_MAX : {1'b0, len_pick};
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            end
            S_SETUP: begin
                if (!req[win_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = win_q;
                end else if (tmr_q == SETUP_LAST) begin
                    state_d = S_RUN;
                    // A generator output already high at release is not a fresh edge.
                    prev_d  = 1'b1;
                end else begin
                    tmr_d = tmr_q + 4'd1;
                end
            end
            S_RUN: begin
                if (!req[win_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = 2'b00;
                    last_d  = win_q;
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if ((cnt_q + CNT_ONE) == len_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
                last_d  = win_q;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= 2'b00;
            sel_q   <= 2'b00;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            last_q  <= last_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            tmr_q   <= tmr_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = (state_q == S_DONE) ? gnt_q : 2'b00;
    assign brg_sel = sel_q;
    assign brg_rst = (state_q != S_RUN);
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_baud_share_arbiter.sv
// tb/tb_baud_share_arbiter.sv - self-checking bench for baud_share_arbiter
module tb_baud_share_arbiter;

    localparam int SETUP_CYC = 2;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0]       sel0, sel1;
    logic [CNT_W-1:0] len0, len1;
    logic             brg_clk_in;
    logic [1:0]       gnt, done, brg_sel;
    logic             brg_rst, busy;

    int nvec = 0;
    int nerr = 0;
    int m_last;

    always #5 clk = ~clk;

    baud_share_arbiter #(.SETUP_CYC(SETUP_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .req(req), .sel0(sel0), .sel1(sel1),
        .len0(len0), .len1(len1), .brg_clk_in(brg_clk_in),
        .gnt(gnt), .done(done), .brg_sel(brg_sel), .brg_rst(brg_rst), .busy(busy)
    );

    typedef struct {
        logic       r;
        logic [1:0] q;
        logic [1:0] s0;
        logic [3:0] l0;
        logic       b;
        logic [1:0] g;
        logic [1:0] d;
        logic [1:0] bs;
        logic       br;
        logic       bz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [1:0] q, input logic [1:0] s0,
                                input logic [3:0] l0, input logic b, input logic [1:0] g,
                                input logic [1:0] d, input logic [1:0] bs, input logic br,
                                input logic bz);
        vec_t v;
        v.r = r; v.q = q; v.s0 = s0; v.l0 = l0; v.b = b;
        v.g = g; v.d = d; v.bs = bs; v.br = br; v.bz = bz;
        return v;
    endfunction

    task automatic step(input logic r, input logic [1:0] q, input logic b);
        rst = r;
        req = q;
        brg_clk_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [1:0] g, input logic [1:0] d,
                       input logic [1:0] s, input logic br, input logic bz);
        nvec++;
        if ({gnt, done, brg_sel, brg_rst, busy} !== {g, d, s, br, bz}) begin
            nerr++;
            $display("FAIL %s: got gnt=%b done=%b brg_sel=%b brg_rst=%b busy=%b, want gnt=%b done=%b brg_sel=%b brg_rst=%b busy=%b",
                     nm, gnt, done, brg_sel, brg_rst, busy, g, d, s, br, bz);
        end
    endtask

    task automatic pulses(input logic [1:0] q, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, q, 1'b0);
            step(1'b1, q, 1'b1);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 2'b00, 1'b0);
        step(1'b0, 2'b00, 1'b0);
    endtask

    initial begin
        rst = 1'b0; req = 2'b00; brg_clk_in = 1'b0;
        sel0 = 2'b00; sel1 = 2'b00; len0 = '0; len1 = '0;

        // Reset, then a single len=3 request from requester 0.
        tbl.push_back(mk(0, 2'b00, 2'b00, 4'd0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 4'd0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(0, 2'b00, 2'b00, 4'd0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(1, 2'b00, 2'b00, 4'd0, 0, 2'b00, 2'b00, 2'b00, 1, 0));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 0, 2'b01, 2'b00, 2'b01, 1, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 0, 2'b01, 2'b00, 2'b01, 1, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 1, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 1, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 0, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 1, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 0, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 1, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 0, 2'b01, 2'b00, 2'b01, 0, 1));
        tbl.push_back(mk(1, 2'b01, 2'b01, 4'd3, 1, 2'b01, 2'b01, 2'b01, 1, 1));
        tbl.push_back(mk(1, 2'b00, 2'b01, 4'd3, 0, 2'b00, 2'b00, 2'b01, 1, 0));
        tbl.push_back(mk(1, 2'b00, 2'b01, 4'd3, 1, 2'b00, 2'b00, 2'b01, 1, 0));

        foreach (tbl[i]) begin
            sel0 = tbl[i].s0;
            len0 = tbl[i].l0;
            step(tbl[i].r, tbl[i].q, tbl[i].b);
            chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].d, tbl[i].bs, tbl[i].br, tbl[i].bz);
        end

        // Tie from reset, then round-robin hand-over.
        do_reset();
        sel0 = 2'b00; sel1 = 2'b11; len0 = 4'd1; len1 = 4'd2;
        step(1, 2'b11, 0);
        chk("tie_first", 2'b01, 2'b00, 2'b00, 1, 1);
        step(1, 2'b11, 0);
        step(1, 2'b11, 0);
        pulses(2'b11, 1);
        chk("tie_done0", 2'b01, 2'b01, 2'b00, 1, 1);
        step(1, 2'b11, 0);
        chk("rr_idle", 2'b00, 2'b00, 2'b00, 1, 0);
        step(1, 2'b11, 0);
        chk("rr_gnt1", 2'b10, 2'b00, 2'b11, 1, 1);
        step(1, 2'b11, 0);
        step(1, 2'b11, 0);
        pulses(2'b11, 2);
        chk("rr_done1", 2'b10, 2'b10, 2'b11, 1, 1);
        step(1, 2'b11, 0);
        step(1, 2'b11, 0);
        chk("rr_again0", 2'b01, 2'b00, 2'b00, 1, 1);
        step(1, 2'b00, 0);

        // len=0 means 2^CNT_W ticks.
        do_reset();
        sel1 = 2'b10; len1 = 4'd0;
        step(1, 2'b10, 0);
        chk("len0_gnt", 2'b10, 2'b00, 2'b10, 1, 1);
        step(1, 2'b10, 0);
        step(1, 2'b10, 0);
        for (int i = 0; i < 16; i++) begin
            pulses(2'b10, 1);
            if (i == 15) chk("len0_done", 2'b10, 2'b10, 2'b10, 1, 1);
            else chk($sformatf("len0_tick%0d", i), 2'b10, 2'b00, 2'b10, 0, 1);
        end
        step(1, 2'b00, 0);

        // Abort after the first tick, pending requester 1 then served.
        do_reset();
        sel0 = 2'b01; len0 = 4'd5; sel1 = 2'b11; len1 = 4'd1;
        step(1, 2'b11, 0);
        chk("abort_gnt", 2'b01, 2'b00, 2'b01, 1, 1);
        step(1, 2'b11, 0);
        step(1, 2'b11, 0);
        pulses(2'b11, 1);
        chk("abort_run", 2'b01, 2'b00, 2'b01, 0, 1);
        step(1, 2'b10, 0);
        chk("abort_idle", 2'b00, 2'b00, 2'b01, 1, 0);
        step(1, 2'b10, 0);
        chk("abort_next", 2'b10, 2'b00, 2'b11, 1, 1);
        step(1, 2'b00, 0);

        // Reset mid-RUN after requester 0 was served last.
        do_reset();
        sel0 = 2'b01; len0 = 4'd1;
        step(1, 2'b01, 0);
        step(1, 2'b01, 0);
        step(1, 2'b01, 0);
        pulses(2'b01, 1);
        chk("rm_done", 2'b01, 2'b01, 2'b01, 1, 1);
        step(1, 2'b00, 0);
        len0 = 4'd4;
        step(1, 2'b01, 0);
        step(1, 2'b01, 0);
        step(1, 2'b01, 0);
        pulses(2'b01, 2);
        chk("rm_run", 2'b01, 2'b00, 2'b01, 0, 1);
        step(0, 2'b01, 0);
        chk("rm_reset", 2'b00, 2'b00, 2'b00, 1, 0);
        step(1, 2'b11, 0);
        chk("rm_tie", 2'b01, 2'b00, 2'b01, 1, 1);
        step(1, 2'b00, 0);

        // Randomized transactions against a transaction-level model.
        do_reset();
        m_last = 1;
        for (int t = 0; t < 60; t++) begin
            logic [1:0] rq, xsel, xg;
            int         win, xlen, ticks, abort_tick, c;
            bit         armed, run, fin, prev_m;
            rq   = 2'($urandom_range(1, 3));
            sel0 = 2'($urandom); sel1 = 2'($urandom);
            len0 = 4'($urandom); len1 = 4'($urandom);
            win  = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : ((m_last == 1) ? 0 : 1);
            xg   = (win == 1) ? 2'b10 : 2'b01;
            xsel = (win == 1) ? sel1 : sel0;
            xlen = (win == 1) ? int'(len1) : int'(len0);
            if (xlen == 0) xlen = 16;
            armed      = ($urandom_range(0, 3) == 0);
            abort_tick = $urandom_range(0, xlen - 1);
            step(1, rq, 1'($urandom));
            chk("rnd_gnt", xg, 2'b00, xsel, 1, 1);
            c = 1; run = 0; fin = 0; ticks = 0; prev_m = 1;
            for (int k = 0; k < 600 && !fin; k++) begin
                bit b, drop;
                b    = 1'($urandom);
                drop = armed && (ticks == abort_tick);
                sel0 = 2'($urandom); sel1 = 2'($urandom);
                len0 = 4'($urandom); len1 = 4'($urandom);
                step(1, drop ? (rq & ~xg) : rq, b);
                if (drop) begin
                    chk("rnd_abort", 2'b00, 2'b00, xsel, 1, 0);
                    m_last = win;
                    fin = 1;
                end else if (!run) begin
                    if (c == SETUP_CYC) begin
                        run = 1;
                        prev_m = 1;
                    end else begin
                        c++;
                    end
                    chk("rnd_setup", xg, 2'b00, xsel, !run, 1);
                end else begin
                    if (b && !prev_m) ticks++;
                    prev_m = b;
                    if (ticks == xlen) begin
                        chk("rnd_done", xg, xg, xsel, 1, 1);
                        step(1, 2'b00, 0);
                        chk("rnd_idle", 2'b00, 2'b00, xsel, 1, 0);
                        m_last = win;
                        fin = 1;
                    end else begin
                        chk("rnd_run", xg, 2'b00, xsel, 0, 1);
                    end
                end
            end
            if (!fin) begin
                nvec++;
                nerr++;
                $display("FAIL rnd_timeout: transaction %0d got no done or abort within 600 cycles, want completion", t);
                do_reset();
                m_last = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/baud_share_arbiter.md
Name: baud_share_arbiter

Overview:
- Shares one baud_rate_generator instance between two requesters (requester 0 = TX framer, requester 1 = RX sampler).
- Arbitrates round-robin between the two requesters.
- For each granted requester: loads that requester's rate select, holds the generator in reset to restart it cleanly, releases it, counts N baud periods, then parks the generator and signals done.
- Sits between the UART framers and the generator; it is the only driver of the generator's sel and rst.

Parameters:
- SETUP_CYC, 2, clk cycles brg_rst stays high after a new sel is loaded (range 1-15).
- CNT_W, 4, width of the length fields and the baud-period counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- req  in  2  request per requester; level; must be held until that requester's done.
- sel0  in  2  rate select for requester 0; sampled at grant.
- sel1  in  2  rate select for requester 1; sampled at grant.
- len0  in  CNT_W  baud periods requested by requester 0; 0 means 2^CNT_W.
- len1  in  CNT_W  baud periods requested by requester 1; 0 means 2^CNT_W.
- brg_clk_in  in  1  clock_out of the generator; synchronous to clk.
- gnt  out  2  one-hot grant.
- done  out  2  one-cycle completion pulse per requester.
- brg_sel  out  2  drives generator sel.
- brg_rst  out  1  drives generator rst; active-high; 1 = generator held.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0 at a clk edge), values on the next cycle:
  - state IDLE, gnt=00, done=00, brg_sel=00, brg_rst=1, busy=0.
  - Counter=0, prev-sample register=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - rst low at any point aborts the operation in flight; no done pulse is issued.
- Edge detect:
  - prev <= brg_clk_in every cycle.
  - tick = brg_clk_in & ~prev.
  - Ticks are counted only in RUN.
- IDLE:
  - brg_rst=1, gnt=00; brg_sel holds its last value.
  - If req!=00: winner is the sole requester; if both request, the winner is the one not equal to last.
  - Next cycle: state SETUP, gnt=onehot(winner), brg_sel=sel_winner, len latched (0 becomes 2^CNT_W), counter=0, setup timer=0.
  - Grant latency is 1 cycle from req seen high in IDLE.
- SETUP:
  - brg_rst=1 for exactly SETUP_CYC cycles, then state RUN with brg_rst=0.
  - prev is forced to 1 on the SETUP->RUN transition, so a generator output already high is not counted as a tick.
- RUN:
  - brg_rst=0.
  - Counter increments on each tick.
  - When the counter reaches len on a tick, the next state is DONE.
- DONE (one cycle):
  - done[winner]=1, gnt still asserted, brg_rst=1, last<=winner.
  - Next cycle: IDLE, gnt=00.
  - A still-pending other request is granted in the following cycle, giving 2 cycles from done to the next gnt.
- Abort:
  - If req[winner] drops while in SETUP or RUN: next cycle IDLE, gnt=00, brg_rst=1, last<=winner, no done pulse.
- Input changes during an operation:
  - sel/len changes after grant are ignored until the next grant.
  - req of the non-granted requester has no effect until IDLE.
- Counter:
  - CNT_W+1 bits so that 2^CNT_W is reachable.
  - Never wraps; the compare is equality.
- Invariants:
  - gnt is one-hot or zero.
  - done is asserted only together with the matching gnt bit.
  - busy = (state != IDLE).

Test Plan:
- Reset: rst=0 for 3 cycles, then rst=1 with req=00 -> gnt=00, done=00, brg_sel=00, brg_rst=1, busy=0 on every cycle.
- Single request: req=01, sel0=01, len0=3 -> gnt=01 one cycle later; brg_sel=01; brg_rst high for 2 cycles then low; done[0] pulses one cycle after the 3rd brg_clk_in rising edge; gnt=00 the cycle after that.
- Tie and round-robin:
  - From reset, req=11 -> requester 0 granted first; requester 1 granted 2 cycles after done[0].
  - Repeat with req=11 -> requester 0 granted again, since last=1.
- len=0: req=10, sel1=10, len1=0 -> done[1] after exactly 16 ticks; brg_sel=10 for the whole operation.
- Abort: drop req[0] after the 1st tick of a len0=5 run -> gnt=00 and brg_rst=1 next cycle; no done pulse; a pending req[1] is then granted.
- Reset mid-RUN: rst=0 during RUN -> all outputs return to reset values the next cycle; no done pulse; arbitration restarts with requester 0 as tie winner.
